// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_conv_arbiter
//  Purpose  : Round-robin arbiter and sequencer that shares one binary/Gray
//             conversion unit between NREQ requesters. One job is in flight
//             at a time; its result is returned registered and tagged with
//             the owning requester's index.
//
//  Ports    : clk        rising-edge clock
//             rst        asynchronous, active-high reset
//             req        per-requester request level, held until its gnt
//             bin_in     operands, requester i at [i*SIZE +: SIZE]
//             mode_in    per-requester mode (0 = bin->Gray, 1 = Gray->bin)
//             gnt        one-hot completion pulse, coincident with res_valid
//             res_valid  one-cycle result strobe
//             res_id     index of the requester owning res_data
//             res_data   conversion result, held until the next res_valid
//             busy       high whenever the sequencer is not idle
//
//  Options  : GRAY_CONV_G2B_EN - when defined, mode_in is honoured and the
//             Gray->bin path is built as an iterative SIZE-cycle converter.
//             When undefined, mode_in is ignored and every job is bin->Gray.
//
//  Revision : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*SIZE-1:0]      bin_in,
    input  logic [NREQ-1:0]           mode_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      res_valid,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [SIZE-1:0]           res_data,
    output logic                      busy
);

    localparam int c_ID_W = $clog2(NREQ);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [c_ID_W-1:0]  r_ptr;
    logic [SIZE-1:0]    r_opnd;
    logic [c_ID_W-1:0]  r_cur_id;
    // Result is built here and only copied to res_data in RESP, so res_data
    // stays stable between strobes even while the iterative path is running.
    logic [SIZE-1:0]    r_acc;

    logic [c_ID_W:0]    w_cand;
    logic [c_ID_W-1:0]  w_sel_id;
    logic               w_sel_found;
    logic [SIZE-1:0]    w_sel_opnd;
    logic [c_ID_W-1:0]  w_ptr_next;

`ifdef GRAY_CONV_G2B_EN
    localparam int                c_K_W   = $clog2(SIZE);
    localparam logic [c_K_W-1:0]  c_K_MAX = c_K_W'(SIZE-1);

    logic               r_cur_mode;
    logic [c_K_W-1:0]   r_k;
    logic               w_sel_mode;
    logic               w_g2b_prev;
    logic               w_g2b_bit;
`else
    logic               w_unused_mode;
    assign w_unused_mode = ^mode_in;
`endif

    // Round-robin search: first asserted request at or above r_ptr, wrapping.
    // The candidate is one bit wider than an index so ptr+i never overflows.
    always_comb begin
        w_sel_id    = '0;
        w_sel_found = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_ptr} + (c_ID_W+1)'(i);
            if (w_cand >= (c_ID_W+1)'(NREQ)) begin
                w_cand = w_cand - (c_ID_W+1)'(NREQ);
            end
            if (!w_sel_found && req[w_cand[c_ID_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_cand[c_ID_W-1:0];
            end
        end
    end

    // Operand mux with constant slice bounds.
    always_comb begin
        w_sel_opnd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_id == c_ID_W'(i)) begin
                w_sel_opnd = bin_in[i*SIZE +: SIZE];
            end
        end
    end

    assign w_ptr_next = (r_cur_id == c_ID_W'(NREQ-1)) ? '0 : r_cur_id + c_ID_W'(1);

`ifdef GRAY_CONV_G2B_EN
    assign w_sel_mode = mode_in[w_sel_id];

    // b[k] = b[k+1] ^ g[k], MSB first. The bit above the MSB is taken as 0.
    // Higher bits of r_acc already hold the binary result when bit k is built.
    always_comb begin
        w_g2b_prev = 1'b0;
        for (int i = 0; i < SIZE-1; i++) begin
            if (r_k == c_K_W'(i)) begin
                w_g2b_prev = r_acc[i+1];
            end
        end
    end

    assign w_g2b_bit = w_g2b_prev ^ r_opnd[r_k];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= '0;
            r_opnd     <= '0;
            r_cur_id   <= '0;
            r_acc      <= '0;
`ifdef GRAY_CONV_G2B_EN
            r_cur_mode <= 1'b0;
            r_k        <= '0;
`endif
            gnt        <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_sel_found) begin
                        r_opnd     <= w_sel_opnd;
                        r_cur_id   <= w_sel_id;
`ifdef GRAY_CONV_G2B_EN
                        r_cur_mode <= w_sel_mode;
                        r_k        <= c_K_MAX;
`endif
                        r_state    <= c_ST_CONV;
                        busy       <= 1'b1;
                    end
                end

                c_ST_CONV: begin
`ifdef GRAY_CONV_G2B_EN
                    if (r_cur_mode) begin
                        r_acc[r_k] <= w_g2b_bit;
                        if (r_k == '0) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_k <= r_k - c_K_W'(1);
                        end
                    end else begin
                        r_acc   <= r_opnd ^ (r_opnd >> 1);
                        r_state <= c_ST_RESP;
                    end
`else
                    r_acc   <= r_opnd ^ (r_opnd >> 1);
                    r_state <= c_ST_RESP;
`endif
                end

                c_ST_RESP: begin
                    res_valid <= 1'b1;
                    gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << r_cur_id;
                    res_id    <= r_cur_id;
                    res_data  <= r_acc;
                    r_ptr     <= w_ptr_next;
                    r_state   <= c_ST_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_conv_arbiter
//  Purpose  : Self-checking bench for gray_conv_arbiter. Expected results are
//             queued when stimulus is applied and compared (id, data, gnt
//             and arrival cycle) when res_valid is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

    localparam int c_SIZE = 8;
    localparam int c_NREQ = 4;
    localparam int c_ID_W = 2;
`ifdef GRAY_CONV_G2B_EN
    localparam bit c_G2B = 1'b1;
`else
    localparam bit c_G2B = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [c_NREQ-1:0]        req;
    logic [c_NREQ*c_SIZE-1:0] bin_in;
    logic [c_NREQ-1:0]        mode_in;
    logic [c_NREQ-1:0]        gnt;
    logic                     res_valid;
    logic [c_ID_W-1:0]        res_id;
    logic [c_SIZE-1:0]        res_data;
    logic                     busy;

    gray_conv_arbiter #(
        .SIZE (c_SIZE),
        .NREQ (c_NREQ)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_in    (bin_in),
        .mode_in   (mode_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [c_ID_W-1:0] id;
        logic [c_SIZE-1:0] data;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [c_SIZE-1:0] bin2gray(input logic [c_SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit k is the XOR of all Gray bits at or above k.
    function automatic logic [c_SIZE-1:0] gray2bin(input logic [c_SIZE-1:0] g);
        logic [c_SIZE-1:0] b;
        b = g;
        for (int s = 1; s < c_SIZE; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [c_SIZE-1:0] exp_res(input logic [c_SIZE-1:0] op, input logic m);
        return (c_G2B && m) ? gray2bin(op) : bin2gray(op);
    endfunction

    function automatic int lat(input logic m);
        return (c_G2B && m) ? c_SIZE + 1 : 2;
    endfunction

    task automatic push_exp(input int id, input logic [c_SIZE-1:0] data, input int when);
        exp_t e;
        e.id   = c_ID_W'(id);
        e.data = data;
        e.cyc  = when;
        sb.push_back(e);
    endtask

    task automatic set_op(input int id, input logic [c_SIZE-1:0] op, input logic m);
        bin_in[id*c_SIZE +: c_SIZE] = op;
        mode_in[id] = m;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // One requester alone: request, scramble its inputs after latching,
    // release at the expected grant, then confirm the block returns idle.
    task automatic run_single(input int id, input logic [c_SIZE-1:0] op,
                              input logic m, input logic [c_SIZE-1:0] exp_data);
        int t;
        set_op(id, op, m);
        req[id] = 1'b1;
        t = cyc + 1;
        push_exp(id, exp_data, t + lat(m));
        @(negedge clk);
        chk("busy_in_job", 32'(busy), 32'd1);
        set_op(id, ~op, ~m);
        while (cyc < t + lat(m)) @(negedge clk);
        req[id] = 1'b0;
        drain(4);
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_job", 32'(busy), 32'd0);
    endtask

    // Result monitor.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_res_valid", 32'(res_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id",    32'(res_id),   32'(mon_e.id));
                chk("res_data",  32'(res_data), 32'(mon_e.data));
                chk("gnt",       32'(gnt),      32'(4'b0001 << mon_e.id));
                chk("res_cycle", 32'(cyc),      32'(mon_e.cyc));
            end
        end else if (gnt != '0) begin
            chk("gnt_without_valid", 32'(gnt), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [c_SIZE-1:0] ops [c_NREQ];
    int t;

    initial begin
        rst     = 1'b1;
        req     = 4'b1111;
        bin_in  = '0;
        mode_in = '0;
        ops[0] = 8'h3C; ops[1] = 8'hA5; ops[2] = 8'h7F; ops[3] = 8'h80;
        for (int i = 0; i < c_NREQ; i++) set_op(i, ops[i], 1'b0);

        // Reset with all requests pending.
        repeat (3) @(negedge clk);
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);

        // All four held: 0,1,2,3,0 spaced three cycles apart.
        rst = 1'b0;
        t = cyc + 1;
        push_exp(0, exp_res(ops[0], 1'b0), t + 2);
        push_exp(1, exp_res(ops[1], 1'b0), t + 5);
        push_exp(2, exp_res(ops[2], 1'b0), t + 8);
        push_exp(3, exp_res(ops[3], 1'b0), t + 11);
        push_exp(0, exp_res(ops[0], 1'b0), t + 14);
        while (cyc < t + 14) @(negedge clk);
        req = '0;
        drain(6);
        repeat (3) @(negedge clk);

        // Single requester 0, known vector.
        run_single(0, 8'hB4, 1'b0, 8'hEE);

        // Requesters 1 and 3 held: strict alternation (pointer currently 1).
        set_op(1, 8'hFF, 1'b0);
        set_op(3, 8'h01, 1'b0);
        req = 4'b1010;
        t = cyc + 1;
        push_exp(1, 8'h80, t + 2);
        push_exp(3, 8'h01, t + 5);
        push_exp(1, 8'h80, t + 8);
        push_exp(3, 8'h01, t + 11);
        while (cyc < t + 11) @(negedge clk);
        req = '0;
        drain(6);
        repeat (3) @(negedge clk);

        // Requester 2 asking for Gray->bin.
        run_single(2, 8'hEE, 1'b1, c_G2B ? 8'hB4 : 8'h99);

        // Reset in the middle of requester 1's conversion (pointer is 3).
        set_op(1, 8'h42, 1'b0);
        req = 4'b0010;
        t = cyc + 1;
        @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_gnt",       32'(gnt),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (c_SIZE + 4) @(negedge clk);
        chk("abort_no_result", 32'(sb.size()), 32'd0);

        // Pointer must be back at 0: with 1 and 3 pending, 1 wins.
        set_op(1, 8'h33, 1'b0);
        set_op(3, 8'hCC, 1'b0);
        req = 4'b1010;
        t = cyc + 1;
        push_exp(1, 8'h2A, t + 2);
        while (cyc < t + 2) @(negedge clk);
        req = '0;
        drain(4);
        repeat (3) @(negedge clk);

        // Another mode-1 request from requester 3.
        run_single(3, 8'h5A, 1'b1, exp_res(8'h5A, 1'b1));

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
